// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares one enable-gated holding register among N_REQ
// requesters. Each grant allows a bounded burst of forwarded writes.
module reg_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int N_REQ     = 4,
  parameter int OWNER_W   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic                   reg_en,
  output logic [WIDTH-1:0]       reg_in,
  output logic                   busy,
  output logic [OWNER_W-1:0]     cur_owner
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, OWN} state_t;

  state_t                         state, state_d;
  logic [N_REQ-1:0]               gnt_d, ack_d;
  logic                           reg_en_d;
  logic [WIDTH-1:0]               reg_in_d;
  logic [OWNER_W-1:0]             owner_d, ptr, ptr_d, pick, idx;
  logic [CNT_W-1:0]               burst_cnt, cnt_d;
  logic                           accept;
  logic [N_REQ-1:0][WIDTH-1:0]    lane_data;

  assign lane_data = req_data;
  assign busy      = (state == OWN);

  // Round-robin search: lowest offset from ptr+1 wins, so walk offsets downward.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = OWNER_W'((int'(ptr) + k) % N_REQ);
      if (req[idx]) pick = idx;
    end
  end

  assign accept = gnt[cur_owner] & req[cur_owner];

  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    ack_d    = '0;
    reg_en_d = 1'b0;
    reg_in_d = reg_in;
    owner_d  = cur_owner;
    ptr_d    = ptr;
    cnt_d    = burst_cnt;
    case (state)
      IDLE: begin
        gnt_d = '0;
        if (|req) begin
          gnt_d[pick] = 1'b1;
          owner_d     = pick;
          ptr_d       = pick;
          cnt_d       = '0;
          state_d     = OWN;
        end
      end
      OWN: begin
        if (accept) begin
          reg_en_d         = 1'b1;
          reg_in_d         = lane_data[cur_owner];
          ack_d[cur_owner] = 1'b1;
          if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
            cnt_d   = '0;
            gnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = burst_cnt + CNT_W'(1);
          end
        end else begin
          // Owner withdrew its request: give the register up.
          cnt_d   = '0;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      ack       <= '0;
      reg_en    <= 1'b0;
      reg_in    <= '0;
      cur_owner <= '0;
      burst_cnt <= '0;
      ptr       <= OWNER_W'(N_REQ - 1);
    end else begin
      state     <= state_d;
      gnt       <= gnt_d;
      ack       <= ack_d;
      reg_en    <= reg_en_d;
      reg_in    <= reg_in_d;
      cur_owner <= owner_d;
      burst_cnt <= cnt_d;
      ptr       <= ptr_d;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a cycle table for the MAX_BURST=4 instance,
// plus hand-written sequences for the full round-robin rotation and MAX_BURST=1.
module tb_reg_write_arbiter;

  logic         clk = 1'b0;
  logic         rst, rst1;
  logic [3:0]   req, req1;
  logic [127:0] req_data, req_data1;
  logic [3:0]   gnt, ack, gnt1, ack1;
  logic         reg_en, reg_en1, busy, busy1;
  logic [31:0]  reg_in, reg_in1;
  logic [1:0]   cur_owner, cur_owner1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.WIDTH(32), .N_REQ(4), .OWNER_W(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .ack(ack),
    .reg_en(reg_en), .reg_in(reg_in), .busy(busy), .cur_owner(cur_owner));

  reg_write_arbiter #(.WIDTH(32), .N_REQ(4), .OWNER_W(2), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst1), .req(req1), .req_data(req_data1), .gnt(gnt1), .ack(ack1),
    .reg_en(reg_en1), .reg_in(reg_in1), .busy(busy1), .cur_owner(cur_owner1));

  typedef struct packed {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] d;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        en;
    logic [31:0] rin;
    logic        busy;
    logic [1:0]  own;
  } vec_t;

  vec_t tv [22];

  // Lane i presents {i, d[27:0]} so the forwarded word identifies its source.
  function automatic logic [127:0] lanes(input logic [31:0] d);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = {4'(i), d[27:0]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0;
    rst1 = 1'b1; req1 = '0; req_data1 = '0;

    //          rst   req      d             gnt      ack      en    rin           busy  own
    tv[0]  = '{1'b1, 4'b1011, 32'h0000_0055, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 2'd0};
    tv[1]  = '{1'b1, 4'b0110, 32'h0000_0066, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 2'd0};
    tv[2]  = '{1'b0, 4'b0010, 32'h0000_00A0, 4'b0010, 4'b0000, 1'b0, 32'h0000_0000, 1'b1, 2'd1};
    tv[3]  = '{1'b0, 4'b0010, 32'h0000_00A0, 4'b0010, 4'b0010, 1'b1, 32'h1000_00A0, 1'b1, 2'd1};
    tv[4]  = '{1'b0, 4'b0010, 32'h0000_00A1, 4'b0010, 4'b0010, 1'b1, 32'h1000_00A1, 1'b1, 2'd1};
    tv[5]  = '{1'b0, 4'b0010, 32'h0000_00A2, 4'b0010, 4'b0010, 1'b1, 32'h1000_00A2, 1'b1, 2'd1};
    tv[6]  = '{1'b0, 4'b0010, 32'h0000_00A3, 4'b0000, 4'b0010, 1'b1, 32'h1000_00A3, 1'b0, 2'd1};
    tv[7]  = '{1'b0, 4'b0010, 32'h0000_00A4, 4'b0010, 4'b0000, 1'b0, 32'h1000_00A3, 1'b1, 2'd1};
    tv[8]  = '{1'b0, 4'b0000, 32'h0000_00A4, 4'b0000, 4'b0000, 1'b0, 32'h1000_00A3, 1'b0, 2'd1};
    tv[9]  = '{1'b0, 4'b0000, 32'h0000_00A4, 4'b0000, 4'b0000, 1'b0, 32'h1000_00A3, 1'b0, 2'd1};
    tv[10] = '{1'b0, 4'b0100, 32'h0000_00B0, 4'b0100, 4'b0000, 1'b0, 32'h1000_00A3, 1'b1, 2'd2};
    tv[11] = '{1'b0, 4'b0100, 32'h0000_00B0, 4'b0100, 4'b0100, 1'b1, 32'h2000_00B0, 1'b1, 2'd2};
    tv[12] = '{1'b1, 4'b0100, 32'h0000_00B1, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 2'd0};
    tv[13] = '{1'b0, 4'b1000, 32'h0000_00C0, 4'b1000, 4'b0000, 1'b0, 32'h0000_0000, 1'b1, 2'd3};
    tv[14] = '{1'b0, 4'b0000, 32'h0000_00C0, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 2'd3};
    tv[15] = '{1'b0, 4'b0101, 32'h0000_00D0, 4'b0001, 4'b0000, 1'b0, 32'h0000_0000, 1'b1, 2'd0};
    tv[16] = '{1'b0, 4'b0101, 32'h0000_00D0, 4'b0001, 4'b0001, 1'b1, 32'h0000_00D0, 1'b1, 2'd0};
    tv[17] = '{1'b0, 4'b0101, 32'h0000_00D1, 4'b0001, 4'b0001, 1'b1, 32'h0000_00D1, 1'b1, 2'd0};
    tv[18] = '{1'b0, 4'b0100, 32'h0000_00D2, 4'b0000, 4'b0000, 1'b0, 32'h0000_00D1, 1'b0, 2'd0};
    tv[19] = '{1'b0, 4'b0100, 32'h0000_00D2, 4'b0100, 4'b0000, 1'b0, 32'h0000_00D1, 1'b1, 2'd2};
    tv[20] = '{1'b0, 4'b0100, 32'h0000_00D2, 4'b0100, 4'b0100, 1'b1, 32'h2000_00D2, 1'b1, 2'd2};
    tv[21] = '{1'b0, 4'b0000, 32'h0000_00D2, 4'b0000, 4'b0000, 1'b0, 32'h2000_00D2, 1'b0, 2'd2};

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst = tv[i].rst; req = tv[i].req; req_data = lanes(tv[i].d);
      step();
      chk($sformatf("v%0d gnt", i),    32'(gnt),       32'(tv[i].gnt));
      chk($sformatf("v%0d ack", i),    32'(ack),       32'(tv[i].ack));
      chk($sformatf("v%0d reg_en", i), 32'(reg_en),    32'(tv[i].en));
      chk($sformatf("v%0d reg_in", i), reg_in,         tv[i].rin);
      chk($sformatf("v%0d busy", i),   32'(busy),      32'(tv[i].busy));
      chk($sformatf("v%0d owner", i),  32'(cur_owner), 32'(tv[i].own));
    end

    // All four requesting: reset the pointer, then expect owners 0,1,2,3,0 with a 5-cycle period.
    @(negedge clk); rst = 1'b1; req = '0;
    @(negedge clk); rst = 1'b0; req = 4'b1111; req_data = lanes(32'h0000_00E0);
    for (int g = 0; g < 5; g++) begin
      int o;
      o = g % 4;
      step();
      chk($sformatf("rr%0d grant", g),  32'(gnt),       32'(1 << o));
      chk($sformatf("rr%0d owner", g),  32'(cur_owner), 32'(o));
      chk($sformatf("rr%0d en_off", g), 32'(reg_en),    32'd0);
      for (int w = 1; w <= 4; w++) begin
        step();
        chk($sformatf("rr%0d.%0d reg_en", g, w), 32'(reg_en), 32'd1);
        chk($sformatf("rr%0d.%0d reg_in", g, w), reg_in,      {4'(o), 28'h00000E0});
        chk($sformatf("rr%0d.%0d ack", g, w),    32'(ack),    32'(1 << o));
        chk($sformatf("rr%0d.%0d gnt", g, w),    32'(gnt),    (w == 4) ? 32'd0 : 32'(1 << o));
      end
    end
    @(negedge clk); req = '0;

    // Single-write bursts: owners alternate 0,1,0,1 with one idle cycle between grants.
    @(negedge clk); rst1 = 1'b0; req1 = 4'b0011; req_data1 = lanes(32'h0000_00F0);
    for (int g = 0; g < 4; g++) begin
      int o;
      o = g % 2;
      step();
      chk($sformatf("mb1_%0d grant", g),  32'(gnt1),       32'(1 << o));
      chk($sformatf("mb1_%0d owner", g),  32'(cur_owner1), 32'(o));
      chk($sformatf("mb1_%0d en_off", g), 32'(reg_en1),    32'd0);
      step();
      chk($sformatf("mb1_%0d reg_en", g), 32'(reg_en1), 32'd1);
      chk($sformatf("mb1_%0d reg_in", g), reg_in1,      {4'(o), 28'h00000F0});
      chk($sformatf("mb1_%0d ack", g),    32'(ack1),    32'(1 << o));
      chk($sformatf("mb1_%0d gnt", g),    32'(gnt1),    32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
